// File: rtl/gpr_pkg.sv
// ============================================================================
// Module : gpr_pkg
// Brief  : Shared widths, types and constants for the GPR file slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gpr_pkg;

  localparam int GPR_XLEN = 32;
  localparam int GPR_NREG = 32;
  localparam int GPR_AW   = $clog2(GPR_NREG);

  typedef logic [GPR_AW-1:0]   reg_addr_t;
  typedef logic [GPR_XLEN-1:0] xword_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

`default_nettype wire

// File: rtl/gpr_scoreboard.sv
// ============================================================================
// Module : gpr_scoreboard
// Brief  : Per-register busy bits tracking outstanding write-backs; gates issue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int  NREG = GPR_NREG,
  parameter int  NWR  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  output logic              iss_ready,
  output logic [NREG-1:0]   busy_vec
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_claim;

  assign iss_ready = (iss_addr == '0) | ~r_busy[iss_addr];
  assign w_claim   = iss_en & iss_ready;

  // Applied lowest priority first so later assignments override earlier ones.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) w_busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
    end
    if (w_claim) w_busy_nxt[iss_addr] = 1'b1;
    if (flush)   w_busy_nxt = '0;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign busy_vec = r_busy;

endmodule

`default_nettype wire

// File: rtl/gpr_file_mp.sv
// ============================================================================
// Module : gpr_file_mp
// Brief  : Multi-port GPR file (x0 hardwired zero) with write-back scoreboard.
//          Define GPR_BYPASS_EN for same-cycle write-to-read forwarding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gpr_file_mp
  import gpr_pkg::*;
#(
  parameter int  XLEN = GPR_XLEN,
  parameter int  NREG = GPR_NREG,
  parameter int  NRD  = 2,
  parameter int  NWR  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic                iss_ready,
  input  logic                flush,
  output logic [NREG-1:0]     busy_vec
);

  logic [XLEN-1:0] r_regs [NREG];

  // Later loop iterations override earlier ones: highest write port wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != '0))
          r_regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  gpr_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR)
  ) u_sb (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .flush     (flush),
    .iss_ready (iss_ready),
    .busy_vec  (busy_vec)
  );

`ifdef GPR_BYPASS_EN
  logic w_claim;
  assign w_claim = iss_en & iss_ready;
`endif

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_reg_data;
    logic            w_reg_busy;

    assign w_addr     = rd_addr[i*AW +: AW];
    assign w_reg_data = (w_addr == '0) ? '0 : r_regs[w_addr];
    assign w_reg_busy = (w_addr == '0) ? 1'b0 : busy_vec[w_addr];

`ifdef GPR_BYPASS_EN
    logic            w_hit;
    logic [XLEN-1:0] w_fwd;

    always_comb begin
      w_hit = 1'b0;
      w_fwd = '0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == w_addr)) begin
          w_hit = 1'b1;
          w_fwd = wr_data[j*XLEN +: XLEN];
        end
      end
      if (w_addr == '0) w_hit = 1'b0;
    end

    // A forwarded value is only stale if a newer producer claims it this cycle.
    assign rd_data[i*XLEN +: XLEN] = w_hit ? w_fwd : w_reg_data;
    assign rd_busy[i] = w_hit ? (w_claim && (iss_addr == w_addr)) : w_reg_busy;
`else
    assign rd_data[i*XLEN +: XLEN] = w_reg_data;
    assign rd_busy[i]              = w_reg_busy;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_gpr_file_mp.sv
// ============================================================================
// Module : tb_gpr_file_mp
// Brief  : Self-checking bench: directed vector table, corner sequences and
//          randomized traffic against an array-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gpr_file_mp;
  import gpr_pkg::*;

  logic        clk;
  logic        rstn;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic        flush;
  logic [31:0] busy_vec;

  gpr_file_mp dut (
    .clk       (clk),
    .rstn      (rstn),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .flush     (flush),
    .busy_vec  (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus currently applied, mirrored for the model.
  logic [1:0]  s_we;
  reg_addr_t   s_wa [2];
  xword_t      s_wd [2];
  logic        s_ie;
  reg_addr_t   s_ia;
  logic        s_fl;
  reg_addr_t   s_ra [2];

  // Reference model: architectural contents and pending-write flags.
  xword_t m_regs [32];
  bit     m_busy [32];

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ie;
    logic [4:0]  ia;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_rbusy;
    logic [31:0] e_bvec;
    logic        e_rdy;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [1:0] we, input reg_addr_t wa0, input xword_t wd0,
                       input reg_addr_t wa1, input xword_t wd1, input logic ie,
                       input reg_addr_t ia, input logic fl, input reg_addr_t ra0,
                       input reg_addr_t ra1);
    s_we = we; s_wa[0] = wa0; s_wd[0] = wd0; s_wa[1] = wa1; s_wd[1] = wd1;
    s_ie = ie; s_ia = ia; s_fl = fl; s_ra[0] = ra0; s_ra[1] = ra1;
    wr_en    = we;
    wr_addr  = {wa1, wa0};
    wr_data  = {wd1, wd0};
    iss_en   = ie;
    iss_addr = ia;
    flush    = fl;
    rd_addr  = {ra1, ra0};
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  function automatic logic exp_ready();
    return (s_ia == 0) || !m_busy[s_ia];
  endfunction

  function automatic logic [31:0] exp_bvec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  function automatic logic [31:0] exp_rd(input int p);
    xword_t d;
    if (s_ra[p] == 0) return '0;
    d = m_regs[s_ra[p]];
`ifdef GPR_BYPASS_EN
    for (int j = 0; j < 2; j++)
      if (s_we[j] && s_wa[j] == s_ra[p]) d = s_wd[j];
`endif
    return d;
  endfunction

  function automatic logic exp_rbusy(input int p);
    if (s_ra[p] == 0) return 1'b0;
`ifdef GPR_BYPASS_EN
    if ((s_we[0] && s_wa[0] == s_ra[p]) || (s_we[1] && s_wa[1] == s_ra[p]))
      return s_ie && exp_ready() && (s_ia == s_ra[p]);
`endif
    return m_busy[s_ra[p]];
  endfunction

  // Register/scoreboard update at a clock edge, straight from the behavioural rules.
  task automatic model_step();
    bit claim;
    claim = s_ie && exp_ready();
    for (int r = 1; r < 32; r++) begin
      bit written;
      written = (s_we[0] && s_wa[0] == r) || (s_we[1] && s_wa[1] == r);
      if (s_fl)                      m_busy[r] = 1'b0;
      else if (claim && s_ia == r)   m_busy[r] = 1'b1;
      else if (written)              m_busy[r] = 1'b0;
    end
    for (int j = 0; j < 2; j++)
      if (s_we[j] && s_wa[j] != 0) m_regs[s_wa[j]] = s_wd[j];
  endtask

  task automatic check_model(input string tag);
    chk({tag, " rd0"}, rd_data[31:0], exp_rd(0));
    chk({tag, " rd1"}, rd_data[63:32], exp_rd(1));
    chk({tag, " rbusy"}, {30'd0, rd_busy}, {30'd0, exp_rbusy(1), exp_rbusy(0)});
    chk({tag, " ready"}, {31'd0, iss_ready}, {31'd0, exp_ready()});
    chk({tag, " bvec"}, busy_vec, exp_bvec());
  endtask

  initial begin
    //        we     wa0 wd0           wa1 wd1       ie  ia  fl  ra0 ra1  e_rd0  e_rd1  rb    bvec     rdy
    vecs[0] = '{2'b11, 7,  32'h11,      7,  32'h22,   1,  0,  0,  0,  1,   0,     0,     2'b00, 32'h0,   1};
    vecs[1] = '{2'b00, 0,  32'h0,       0,  32'h0,    1,  3,  0,  7,  0,   32'h22,0,     2'b00, 32'h0,   1};
    vecs[2] = '{2'b01, 0,  32'h1234,    0,  32'h0,    1,  3,  0,  3,  7,   0,     32'h22,2'b01, 32'h8,   0};
    vecs[3] = '{2'b10, 0,  32'h0,       3,  32'h55,   0,  3,  0,  0,  7,   0,     32'h22,2'b00, 32'h8,   0};
    vecs[4] = '{2'b00, 0,  32'h0,       0,  32'h0,    0,  3,  0,  3,  0,   32'h55,0,     2'b00, 32'h0,   1};
    vecs[5] = '{2'b01, 3,  32'h66,      0,  32'h0,    1,  3,  0,  7,  0,   32'h22,0,     2'b00, 32'h0,   1};
    vecs[6] = '{2'b00, 0,  32'h0,       0,  32'h0,    1,  4,  0,  3,  0,   32'h66,0,     2'b01, 32'h8,   1};
    vecs[7] = '{2'b00, 0,  32'h0,       0,  32'h0,    1,  9,  0,  4,  9,   0,     0,     2'b01, 32'h18,  1};
    vecs[8] = '{2'b01, 4,  32'hA,       0,  32'h0,    1,  12, 1,  9,  3,   0,     32'h66,2'b11, 32'h218, 1};
    vecs[9] = '{2'b00, 0,  32'h0,       0,  32'h0,    0,  9,  0,  4,  9,   32'hA, 0,     2'b00, 32'h0,   1};

    rstn = 1'b0;
    apply(2'b00, 0, 0, 0, 0, 1'b0, 5, 1'b0, 5, 0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset rd0", rd_data[31:0], 32'h0);
    chk("reset bvec", busy_vec, 32'h0);
    chk("reset ready", {31'd0, iss_ready}, 32'h1);
    chk("reset rbusy", {30'd0, rd_busy}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      apply(vecs[k].we, vecs[k].wa0, vecs[k].wd0, vecs[k].wa1, vecs[k].wd1,
            vecs[k].ie, vecs[k].ia, vecs[k].fl, vecs[k].ra0, vecs[k].ra1);
      #1;
      chk($sformatf("vec%0d rd0", k), rd_data[31:0], vecs[k].e_rd0);
      chk($sformatf("vec%0d rd1", k), rd_data[63:32], vecs[k].e_rd1);
      chk($sformatf("vec%0d rbusy", k), {30'd0, rd_busy}, {30'd0, vecs[k].e_rbusy});
      chk($sformatf("vec%0d bvec", k), busy_vec, vecs[k].e_bvec);
      chk($sformatf("vec%0d ready", k), {31'd0, iss_ready}, {31'd0, vecs[k].e_rdy});
      @(posedge clk);
      model_step();
    end

    // Asynchronous reset asserted mid-cycle with live state.
    @(negedge clk);
    apply(2'b01, 5, 32'hDEADBEEF, 0, 0, 1'b1, 5, 1'b0, 0, 0);
    @(posedge clk);
    model_step();
    @(negedge clk);
    apply(2'b00, 0, 0, 0, 0, 1'b0, 5, 1'b0, 5, 0);
    #1;
    chk("pre-rst x5", rd_data[31:0], 32'hDEADBEEF);
    chk("pre-rst bvec", busy_vec, exp_bvec());
    #2;
    rstn = 1'b0;
    #1;
    chk("async rst x5", rd_data[31:0], 32'h0);
    chk("async rst bvec", busy_vec, 32'h0);
    chk("async rst ready", {31'd0, iss_ready}, 32'h1);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;

    // Same-cycle write and read of x12.
    @(negedge clk);
    apply(2'b01, 12, 32'hCAFE, 0, 0, 1'b0, 0, 1'b0, 12, 0);
    #1;
`ifdef GPR_BYPASS_EN
    chk("bypass same", rd_data[31:0], 32'hCAFE);
`else
    chk("bypass same", rd_data[31:0], 32'h0);
`endif
    @(posedge clk);
    model_step();
    @(negedge clk);
    apply(2'b00, 0, 0, 0, 0, 1'b0, 0, 1'b0, 12, 0);
    #1;
    chk("bypass next", rd_data[31:0], 32'hCAFE);
    @(posedge clk);
    model_step();

    // Randomized traffic on a narrowed address range to force collisions.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      apply(2'($urandom_range(0, 3)),
            5'($urandom_range(0, 15)), $urandom,
            5'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
            ($urandom_range(0, 15) == 0),
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      #1;
      check_model($sformatf("rand%0d", c));
      @(posedge clk);
      model_step();
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
